// File: rtl/input4_sweep_gen.sv
`default_nettype none
// ============================================================================
//  Module   : input4_sweep_gen
//  Purpose  : Steps a 4-input gate stage through all 16 input patterns and
//             samples its {e,f,g} response at the end of each hold window.
//  Revision : 1.0  initial release
// ============================================================================
module input4_sweep_gen #(
  parameter int HOLD_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       resp_e,
  input  logic       resp_f,
  input  logic       resp_g,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       busy,
  output logic       done,
  output logic       sample_valid,
  output logic [3:0] sample_idx,
  output logic [2:0] sample_resp
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [3:0] C_IDX_LAST = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_idx, w_idx_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_sv, w_sv_nxt;
  logic [3:0]       r_sidx, w_sidx_nxt;
  logic [2:0]       r_sresp, w_sresp_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= 4'd0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sv    <= 1'b0;
      r_sidx  <= 4'd0;
      r_sresp <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_sv    <= w_sv_nxt;
      r_sidx  <= w_sidx_nxt;
      r_sresp <= w_sresp_nxt;
    end
  end

  // r_idx is forced to zero outside RUN so it can drive a..d directly.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = r_done;
    w_sv_nxt    = 1'b0;
    w_sidx_nxt  = r_sidx;
    w_sresp_nxt = r_sresp;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE && abort) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b0;
        end else if (start) begin
          w_state_nxt = S_RUN;
          w_idx_nxt   = 4'd0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b1;
          w_done_nxt  = 1'b0;
        end
      end

      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = 4'd0;
          w_cnt_nxt   = '0;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b0;
        end else if (r_cnt == C_CNT_LAST) begin
          w_sv_nxt    = 1'b1;
          w_sidx_nxt  = r_idx;
          w_sresp_nxt = {resp_e, resp_f, resp_g};
          w_cnt_nxt   = '0;
          if (r_idx == C_IDX_LAST) begin
            w_state_nxt = S_DONE;
            w_idx_nxt   = 4'd0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 4'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = 4'd0;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
      end
    endcase
  end

  assign {a, b, c, d}  = r_idx;
  assign busy          = r_busy;
  assign done          = r_done;
  assign sample_valid  = r_sv;
  assign sample_idx    = r_sidx;
  assign sample_resp   = r_sresp;

endmodule
`default_nettype wire

// File: tb/tb_input4_sweep_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input4_sweep_gen
//  Purpose  : Scoreboard bench driving two sweep generators (hold 20 and 1)
//             with shared start/abort/reset and a behavioural gate model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_input4_sweep_gen;

  localparam int H0 = 20;
  localparam int H1 = 1;

  typedef struct {
    int         cyc;
    logic [3:0] idx;
    logic [2:0] resp;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [15:0] f_tab, g_tab;

  logic a0, b0, c0, d0, busy0, done0, sv0;
  logic a1, b1, c1, d1, busy1, done1, sv1;
  logic [3:0] sidx0, sidx1;
  logic [2:0] sresp0, sresp1;
  logic [3:0] pat0, pat1;
  logic e0, f0, g0, e1, f1, g1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int st[2];
  int t0[2];
  exp_t q[2][$];

  always #5 clk = ~clk;

  assign pat0 = {a0, b0, c0, d0};
  assign pat1 = {a1, b1, c1, d1};
  assign e0 = ~&pat0;
  assign f0 = f_tab[pat0];
  assign g0 = g_tab[pat0];
  assign e1 = ~&pat1;
  assign f1 = f_tab[pat1];
  assign g1 = g_tab[pat1];

  input4_sweep_gen #(.HOLD_CYCLES(H0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .resp_e(e0), .resp_f(f0), .resp_g(g0),
    .a(a0), .b(b0), .c(c0), .d(d0),
    .busy(busy0), .done(done0), .sample_valid(sv0),
    .sample_idx(sidx0), .sample_resp(sresp0)
  );

  input4_sweep_gen #(.HOLD_CYCLES(H1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .resp_e(e1), .resp_f(f1), .resp_g(g1),
    .a(a1), .b(b1), .c(c1), .d(d1),
    .busy(busy1), .done(done1), .sample_valid(sv1),
    .sample_idx(sidx1), .sample_resp(sresp1)
  );

  function automatic int hold(int k);
    return (k == 0) ? H0 : H1;
  endfunction

  function automatic logic [2:0] gate_resp(int i);
    logic [3:0] p;
    p = i[3:0];
    return {~&p, f_tab[p], g_tab[p]};
  endfunction

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_zero();
    chk("rst pat0", int'(pat0), 0);   chk("rst pat1", int'(pat1), 0);
    chk("rst busy0", int'(busy0), 0); chk("rst busy1", int'(busy1), 0);
    chk("rst done0", int'(done0), 0); chk("rst done1", int'(done1), 0);
    chk("rst sv0", int'(sv0), 0);     chk("rst sv1", int'(sv1), 0);
    chk("rst sidx0", int'(sidx0), 0); chk("rst sidx1", int'(sidx1), 0);
    chk("rst sresp0", int'(sresp0), 0); chk("rst sresp1", int'(sresp1), 0);
  endtask

  // Reference model: 0=idle, 1=sweeping, 2=finished; expected samples queued on accept.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        st[k] = 0;
        q[k].delete();
      end
    end else begin
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (st[k] == 1 && abort) begin
          st[k] = 0;
          q[k].delete();
        end else if (st[k] == 1 && cyc == t0[k] + 16 * hold(k)) begin
          st[k] = 2;
        end else if (st[k] == 2 && abort) begin
          st[k] = 0;
        end else if (st[k] != 1 && start) begin
          st[k] = 1;
          t0[k] = cyc;
          for (int i = 0; i < 16; i++)
            q[k].push_back('{cyc + (i + 1) * hold(k), 4'(i), gate_resp(i)});
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        logic [3:0] pat;
        logic       bsy, dn, sv;
        logic [3:0] sidx;
        logic [2:0] sresp;
        exp_t       e;
        pat   = (k == 0) ? pat0 : pat1;
        bsy   = (k == 0) ? busy0 : busy1;
        dn    = (k == 0) ? done0 : done1;
        sv    = (k == 0) ? sv0 : sv1;
        sidx  = (k == 0) ? sidx0 : sidx1;
        sresp = (k == 0) ? sresp0 : sresp1;
        chk($sformatf("dut%0d busy", k), int'(bsy), (st[k] == 1) ? 1 : 0);
        chk($sformatf("dut%0d done", k), int'(dn), (st[k] == 2) ? 1 : 0);
        chk($sformatf("dut%0d abcd", k), int'(pat),
            (st[k] == 1) ? (cyc - t0[k]) / hold(k) : 0);
        while (q[k].size() > 0 && q[k][0].cyc < cyc) begin
          chk($sformatf("dut%0d sample_missing idx%0d", k, q[k][0].idx), 0, 1);
          void'(q[k].pop_front());
        end
        if (sv) begin
          if (q[k].size() == 0 || q[k][0].cyc != cyc) begin
            chk($sformatf("dut%0d sample_unexpected", k), 1, 0);
          end else begin
            e = q[k].pop_front();
            chk($sformatf("dut%0d sample_idx", k), int'(sidx), int'(e.idx));
            chk($sformatf("dut%0d sample_resp", k), int'(sresp), int'(e.resp));
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
  endtask

  task automatic new_tables();
    f_tab = 16'($urandom);
    g_tab = 16'($urandom);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    f_tab = 16'h0; g_tab = 16'h0;
    repeat (3) @(negedge clk);
    chk_zero();
    rst = 1'b0;
    repeat (100) @(negedge clk);

    // plain sweep with f=g=0: responses 100 except pattern 15
    pulse_start();
    repeat (330) @(negedge clk);

    // start re-pulsed around pattern 5 must be ignored by the hold-20 unit
    new_tables();
    pulse_start();
    repeat (99 + $urandom_range(0, 15)) @(negedge clk);
    pulse_start();
    repeat (330) @(negedge clk);

    // abort mid-window at pattern 7, then a fresh sweep
    new_tables();
    pulse_start();
    repeat (139 + $urandom_range(1, 17)) @(negedge clk);
    pulse_abort();
    repeat (30) @(negedge clk);
    pulse_start();
    repeat (330) @(negedge clk);

    // asynchronous reset between edges at pattern 9
    new_tables();
    pulse_start();
    repeat (179 + $urandom_range(1, 15)) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_zero();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    pulse_start();
    repeat (330) @(negedge clk);

    // randomized start/abort traffic
    for (int it = 0; it < 3; it++) begin
      new_tables();
      pulse_start();
      for (int j = 0; j < 330; j++) begin
        @(negedge clk);
        start = ($urandom_range(0, 59) == 0);
        abort = ($urandom_range(0, 399) == 0);
      end
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      repeat (340) @(negedge clk);
    end

    chk("dut0 queue_drained", q[0].size(), 0);
    chk("dut1 queue_drained", q[1].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/input4_sweep_gen.md
# input4_sweep_gen

Sequential stimulus generator and response sampler for the 4-input NAND-gate stage. On a start request it steps the stage's inputs a,b,c,d through all 16 combinations in binary order, holding each for a programmable number of cycles. It samples the stage's three outputs e,f,g at the end of each hold window and presents each sample with its pattern index. It sits directly upstream of the gate stage, driving its inputs, and also consumes that stage's outputs.

## Interface
Parameters:
- HOLD_CYCLES, 20, cycles each pattern is held (legal range 1..65535)

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  sweep request; accepted only in IDLE or DONE
- abort  in  1  synchronous sweep cancel
- resp_e, resp_f, resp_g  in  1 each  outputs of the gate stage
- a, b, c, d  out  1 each  stimulus to the gate stage; {a,b,c,d} = pattern index, a is MSB
- busy  out  1  sweep in progress
- done  out  1  sweep completed, level
- sample_valid  out  1  one-cycle pulse, sample fields valid
- sample_idx  out  4  pattern index that the sample belongs to
- sample_resp  out  3  {e,f,g} captured for that pattern

## Operation
- States:
  - IDLE (after reset)
  - RUN
  - DONE
- Internal state:
  - 4-bit pattern index idx
  - hold counter cnt, width $clog2(HOLD_CYCLES), minimum 1 bit; counts 0..HOLD_CYCLES-1
- IDLE/DONE + start=1:
  - go to RUN; idx=0, cnt=0
  - busy=1, done=0
- RUN, cnt < HOLD_CYCLES-1: cnt+1; a..d held.
- RUN, cnt = HOLD_CYCLES-1 (end of window):
  - sample_valid=1
  - sample_idx=idx
  - sample_resp={resp_e,resp_f,resp_g} as present in that cycle
  - cnt=0
  - if idx<15: idx+1, a..d update together with the sample
  - if idx=15: go to DONE; busy=0, done=1, a..d=0
- DONE: done stays 1 until the next accepted start; that start clears it in the same edge that enters RUN.
- start while in RUN is ignored; the sweep is not restarted.
- abort=1 in RUN:
  - next edge goes to IDLE; busy=0, done=0, a..d=0
  - no sample_valid on that edge, even at end of window
  - abort takes priority over start
- abort in IDLE or DONE: no effect, except in DONE it also clears done to 0 and returns to IDLE.
- Index arithmetic is 4-bit. It never wraps, because the terminal check at 15 precedes the increment.
- a..d come directly from registers, with no combinational path from start to a..d.
- sample_resp is registered; resp_* is assumed stable in the last cycle of each window.

## Timing
- Reset: outputs and state take reset values immediately on assertion:
  - a,b,c,d=0
  - busy=0, done=0, sample_valid=0
  - sample_idx=0, sample_resp=0
  - state=IDLE, idx=0, cnt=0
- Reset mid-sweep: returns to IDLE with no pulse and no done.
- Start accepted at edge T0: a..d=0000 and busy=1 from T0.
- Pattern i is driven from edge T0+i*HOLD_CYCLES to T0+(i+1)*HOLD_CYCLES.
- sample_valid for pattern i is high for exactly one cycle, after edge T0+(i+1)*HOLD_CYCLES.
- Last sample and done=1 occur at edge T0+16*HOLD_CYCLES; busy=0 at the same edge.
- Total sweep length is 16*HOLD_CYCLES cycles; there are no idle cycles between patterns.
- HOLD_CYCLES=1: the pattern changes every cycle, and sample_valid stays high for 16 consecutive cycles.
- Restart from DONE: start at edge D gives a..d=0000 at D with no gap cycle.

## Test plan
- Reset then idle, HOLD_CYCLES=20, start=0 for 100 cycles -> a..d=0000, busy=0, done=0, sample_valid never asserts.
- HOLD_CYCLES=20, single start pulse, resp tied so that e=~(a&b&c&d) and f=g=0:
  - exactly 16 sample_valid pulses, 20 cycles apart
  - sample_idx = 0..15 in order
  - sample_resp = 3'b100 for idx 0..14 and 3'b000 for idx 15
  - done=1 at cycle 320 after start
- HOLD_CYCLES=1, start -> sample_valid high 16 consecutive cycles, a..d counts 0000..1111 one per cycle, then done=1.
- Start re-pulsed at pattern 5 during RUN -> ignored; sweep still ends after 16 samples at the original 320-cycle mark.
- Abort at pattern 7 mid-window -> next edge busy=0, done=0, a..d=0000, no further pulses; a following start begins again at idx 0.
- rst asserted asynchronously mid-sweep (between edges, pattern 9) -> all outputs 0 immediately; after release, start runs a full fresh sweep from idx 0.
